// File: rtl/uart_axi_fifo.sv
// AXI4-Lite UART with TX/RX byte FIFOs, optional parity and a level interrupt.
// Register map: 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS (W1C flags), 0xC CONTROL.
module uart_axi_fifo #(
    parameter int unsigned CLK_FREQUENCY      = 100_000_000,
    parameter int unsigned BAUD_RATE          = 115_200,
    parameter bit          PARITY_EN          = 1'b1,
    parameter bit          PARITY_ODD         = 1'b1,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [1:0]                    s_axi_bresp,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          tx_out,
    input  logic                          rx_in,
    output logic                          irq
);

    localparam int unsigned BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CNT_W      = $clog2(BIT_CYCLES + 1);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned PW         = AW + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_RXDATA  = 2'd1;
    localparam logic [1:0] A_STATUS  = 2'd2;
    localparam logic [1:0] A_CONTROL = 2'd3;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // AXI handshake
    logic        r_bvalid;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        w_wr_acc;
    logic        w_rd_acc;
    logic [1:0]  w_awsel;
    logic [1:0]  w_arsel;
    logic [31:0] w_rdata;

    // Control and flags
    logic       r_rx_irq_en;
    logic       r_tx_irq_en;
    logic       r_tx_flush;
    logic       r_rx_flush;
    logic       r_tx_ovf;
    logic       r_rx_ovf;
    logic       r_parity_err;
    logic       r_frame_err;
    logic       r_irq;
    logic [3:0] w_clr;

    // FIFOs
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_tx_wptr;
    logic [PW-1:0] r_tx_rptr;
    logic [PW-1:0] r_rx_wptr;
    logic [PW-1:0] r_rx_rptr;
    logic          w_tx_empty;
    logic          w_tx_full;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_tx_push_req;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic [7:0]    w_tx_head;
    logic [7:0]    w_rx_head;

    // TX engine
    tx_state_e        r_tx_state;
    tx_state_e        w_tx_state_d;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] w_tx_cnt_d;
    logic [2:0]       r_tx_bit;
    logic [2:0]       w_tx_bit_d;
    logic [7:0]       r_tx_data;
    logic [7:0]       w_tx_data_d;
    logic             r_tx_par;
    logic             w_tx_par_d;
    logic             r_tx_out;
    logic             w_tx_out_d;
    logic             w_tx_busy;

    // RX engine
    logic [1:0]       r_rx_sync;
    logic             r_rx_prev;
    logic             w_rx_line;
    rx_state_e        r_rx_state;
    rx_state_e        w_rx_state_d;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [CNT_W-1:0] w_rx_cnt_d;
    logic [2:0]       r_rx_bit;
    logic [2:0]       w_rx_bit_d;
    logic [7:0]       r_rx_data;
    logic [7:0]       w_rx_data_d;
    logic             r_rx_par;
    logic             w_rx_par_d;
    logic             w_rx_good;
    logic             w_rx_perr_set;
    logic             w_rx_ferr_set;
    logic             w_rx_ovf_set;
    logic             w_tx_ovf_set;

    logic w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_wdata[31:8],
                        s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ------------------------------------------------------------------ AXI
    // Ready is gated by reset so nothing handshakes while the block is held in reset.
    assign w_wr_acc = s_axi_aresetn & s_axi_awvalid & s_axi_wvalid & ~r_bvalid;
    assign w_rd_acc = s_axi_aresetn & s_axi_arvalid & ~r_rvalid;
    assign w_awsel  = s_axi_awaddr[3:2];
    assign w_arsel  = s_axi_araddr[3:2];

    assign s_axi_awready = w_wr_acc;
    assign s_axi_wready  = w_wr_acc;
    assign s_axi_arready = w_rd_acc;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;

    always_comb begin
        w_rdata = 32'h0;
        case (w_arsel)
            A_RXDATA:  w_rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            A_STATUS:  w_rdata = {23'h0, w_tx_busy, r_frame_err, r_parity_err, r_rx_ovf,
                                  r_tx_ovf, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
            A_CONTROL: w_rdata = {30'h0, r_tx_irq_en, r_rx_irq_en};
            default:   w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            if (w_wr_acc) r_bvalid <= 1'b1;
            else if (s_axi_bready) r_bvalid <= 1'b0;
            if (w_rd_acc) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
            end else if (s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------ control / flags
    assign w_clr = (w_wr_acc && w_awsel == A_STATUS) ? s_axi_wdata[7:4] : 4'h0;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rx_irq_en  <= 1'b0;
            r_tx_irq_en  <= 1'b0;
            r_tx_flush   <= 1'b0;
            r_rx_flush   <= 1'b0;
            r_tx_ovf     <= 1'b0;
            r_rx_ovf     <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_tx_flush <= 1'b0;
            r_rx_flush <= 1'b0;
            if (w_wr_acc && w_awsel == A_CONTROL) begin
                r_rx_irq_en <= s_axi_wdata[0];
                r_tx_irq_en <= s_axi_wdata[1];
                r_tx_flush  <= s_axi_wdata[2];
                r_rx_flush  <= s_axi_wdata[3];
            end
            // Set wins over a coincident W1C clear.
            r_tx_ovf     <= w_tx_ovf_set  | (r_tx_ovf     & ~w_clr[0]);
            r_rx_ovf     <= w_rx_ovf_set  | (r_rx_ovf     & ~w_clr[1]);
            r_parity_err <= w_rx_perr_set | (r_parity_err & ~w_clr[2]);
            r_frame_err  <= w_rx_ferr_set | (r_frame_err  & ~w_clr[3]);
            r_irq        <= (r_rx_irq_en & ~w_rx_empty) | (r_tx_irq_en & w_tx_empty);
        end
    end

    assign irq = r_irq;

    // ---------------------------------------------------------------- FIFOs
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) &&
                        (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) &&
                        (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
    assign w_tx_head  = r_tx_mem[r_tx_rptr[AW-1:0]];
    assign w_rx_head  = r_rx_mem[r_rx_rptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_tx_push_req = w_wr_acc && (w_awsel == A_TXDATA);
    assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
    assign w_tx_ovf_set  = w_tx_push_req && !w_tx_push;
    assign w_rx_pop      = w_rd_acc && (w_arsel == A_RXDATA) && !w_rx_empty;
    assign w_rx_push     = w_rx_good && (!w_rx_full || w_rx_pop);
    assign w_rx_ovf_set  = w_rx_good && !w_rx_push;

    always_ff @(posedge s_axi_aclk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= s_axi_wdata[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= r_rx_data;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
            if (r_tx_flush) r_tx_rptr <= r_tx_wptr;
            else if (w_tx_pop) r_tx_rptr <= r_tx_rptr + PW'(1);
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
            if (r_rx_flush) r_rx_rptr <= r_rx_wptr;
            else if (w_rx_pop) r_rx_rptr <= r_rx_rptr + PW'(1);
        end
    end

    // ------------------------------------------------------------------- TX
    assign w_tx_busy = (r_tx_state != TxIdle);
    assign tx_out    = r_tx_out;

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt + CNT_W'(1);
        w_tx_bit_d   = r_tx_bit;
        w_tx_data_d  = r_tx_data;
        w_tx_par_d   = r_tx_par;
        w_tx_pop     = 1'b0;
        unique case (r_tx_state)
            TxIdle: begin
                w_tx_cnt_d = '0;
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_data_d  = w_tx_head;
                    w_tx_par_d   = (^w_tx_head) ^ PARITY_ODD;
                    w_tx_state_d = TxStart;
                end
            end
            TxStart: if (r_tx_cnt == BIT_LAST) begin
                w_tx_cnt_d   = '0;
                w_tx_bit_d   = 3'd0;
                w_tx_state_d = TxData;
            end
            TxData: if (r_tx_cnt == BIT_LAST) begin
                w_tx_cnt_d = '0;
                if (r_tx_bit == 3'd7) w_tx_state_d = PARITY_EN ? TxParity : TxStop;
                else w_tx_bit_d = r_tx_bit + 3'd1;
            end
            TxParity: if (r_tx_cnt == BIT_LAST) begin
                w_tx_cnt_d   = '0;
                w_tx_state_d = TxStop;
            end
            TxStop: if (r_tx_cnt == BIT_LAST) begin
                w_tx_cnt_d   = '0;
                w_tx_state_d = TxIdle;
                // Chain straight into the next start bit to avoid an idle gap.
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_data_d  = w_tx_head;
                    w_tx_par_d   = (^w_tx_head) ^ PARITY_ODD;
                    w_tx_state_d = TxStart;
                end
            end
            default: w_tx_state_d = TxIdle;
        endcase

        case (w_tx_state_d)
            TxStart:  w_tx_out_d = 1'b0;
            TxData:   w_tx_out_d = w_tx_data_d[w_tx_bit_d];
            TxParity: w_tx_out_d = w_tx_par_d;
            default:  w_tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_tx_state <= TxIdle;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_data  <= 8'h0;
            r_tx_par   <= 1'b0;
            r_tx_out   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_bit   <= w_tx_bit_d;
            r_tx_data  <= w_tx_data_d;
            r_tx_par   <= w_tx_par_d;
            r_tx_out   <= w_tx_out_d;
        end
    end

    // ------------------------------------------------------------------- RX
    assign w_rx_line = r_rx_sync[1];

    always_comb begin
        w_rx_state_d  = r_rx_state;
        w_rx_cnt_d    = r_rx_cnt + CNT_W'(1);
        w_rx_bit_d    = r_rx_bit;
        w_rx_data_d   = r_rx_data;
        w_rx_par_d    = r_rx_par;
        w_rx_good     = 1'b0;
        w_rx_perr_set = 1'b0;
        w_rx_ferr_set = 1'b0;
        unique case (r_rx_state)
            RxIdle: begin
                w_rx_cnt_d = '0;
                if (r_rx_prev && !w_rx_line) w_rx_state_d = RxStart;
            end
            RxStart: if (r_rx_cnt == HALF_LAST) begin
                w_rx_cnt_d   = '0;
                w_rx_bit_d   = 3'd0;
                w_rx_state_d = w_rx_line ? RxIdle : RxData;
            end
            RxData: if (r_rx_cnt == BIT_LAST) begin
                w_rx_cnt_d  = '0;
                w_rx_data_d = {w_rx_line, r_rx_data[7:1]};
                if (r_rx_bit == 3'd7) w_rx_state_d = PARITY_EN ? RxParity : RxStop;
                else w_rx_bit_d = r_rx_bit + 3'd1;
            end
            RxParity: if (r_rx_cnt == BIT_LAST) begin
                w_rx_cnt_d   = '0;
                w_rx_par_d   = w_rx_line;
                w_rx_state_d = RxStop;
            end
            RxStop: if (r_rx_cnt == BIT_LAST) begin
                // Back to idle at mid-stop so the next start edge is never missed.
                w_rx_cnt_d   = '0;
                w_rx_state_d = RxIdle;
                if (!w_rx_line) w_rx_ferr_set = 1'b1;
                else if (PARITY_EN && (r_rx_par != ((^r_rx_data) ^ PARITY_ODD)))
                    w_rx_perr_set = 1'b1;
                else w_rx_good = 1'b1;
            end
            default: w_rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RxIdle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_data  <= 8'h0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], rx_in};
            r_rx_prev  <= w_rx_line;
            r_rx_state <= w_rx_state_d;
            r_rx_cnt   <= w_rx_cnt_d;
            r_rx_bit   <= w_rx_bit_d;
            r_rx_data  <= w_rx_data_d;
            r_rx_par   <= w_rx_par_d;
        end
    end

endmodule

// File: tb/tb_uart_axi_fifo.sv
// Directed bench for uart_axi_fifo at 10 clocks per bit, 4-deep FIFOs, odd parity.
module tb_uart_axi_fifo;

    logic        clk = 1'b0;
    logic        s_axi_aresetn;
    logic        s_axi_awvalid, s_axi_awready;
    logic [3:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic        tx_out;
    logic        irq;
    logic        r_loop;
    logic        r_rx_drv;
    logic        w_rx_in;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] mon_q[$];

    assign w_rx_in = r_loop ? tx_out : r_rx_drv;

    always #5 clk = ~clk;

    uart_axi_fifo #(
        .CLK_FREQUENCY     (1_000_000),
        .BAUD_RATE         (100_000),
        .PARITY_EN         (1'b1),
        .PARITY_ODD        (1'b1),
        .FIFO_DEPTH        (4),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(s_axi_aresetn),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (s_axi_awprot),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (s_axi_arprot),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .tx_out       (tx_out),
        .rx_in        (w_rx_in),
        .irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            #1 acc = s_axi_awready;
            @(posedge clk);
        end
        check("aw_accept", {31'h0, acc}, 32'h1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        for (int n = 0; n < 20 && !s_axi_bvalid; n++) @(negedge clk);
        check("bvalid", {31'h0, s_axi_bvalid}, 32'h1);
        check("bresp", {30'h0, s_axi_bresp}, 32'h0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            #1 acc = s_axi_arready;
            @(posedge clk);
        end
        check("ar_accept", {31'h0, acc}, 32'h1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        for (int n = 0; n < 20 && !s_axi_rvalid; n++) @(negedge clk);
        check("rvalid", {31'h0, s_axi_rvalid}, 32'h1);
        check("rresp", {30'h0, s_axi_rresp}, 32'h0);
        data = s_axi_rdata;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic par, input logic stp);
        logic [10:0] fr;
        fr = {stp, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            r_rx_drv = fr[i];
            repeat (9) @(negedge clk);
        end
        @(negedge clk);
        r_rx_drv = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Passive line decoder: collects each byte seen on tx_out.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_out === 1'b0) begin
                repeat (5) @(negedge clk);
                if (tx_out === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (10) @(negedge clk);
                        b[i] = tx_out;
                    end
                    repeat (20) @(negedge clk);
                    mon_q.push_back(b);
                end
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame;
        int          n;
        int          low;
        logic        hold_ok;
        logic        blocked_ok;

        s_axi_aresetn = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_awaddr  = 4'h0;
        s_axi_awprot  = 3'h0;
        s_axi_wvalid  = 1'b0;
        s_axi_wdata   = 32'h0;
        s_axi_wstrb   = 4'hF;
        s_axi_bready  = 1'b1;
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = 4'h0;
        s_axi_arprot  = 3'h0;
        s_axi_rready  = 1'b1;
        r_loop        = 1'b0;
        r_rx_drv      = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_out", {31'h0, tx_out}, 32'h1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        s_axi_aresetn = 1'b1;
        axi_read(4'h8, rd);
        check("rst_status", rd, 32'h00A);
        axi_read(4'h0, rd);
        check("txdata_reads_0", rd, 32'h0);

        // Single frame 0xA5 on the wire
        axi_write(4'h0, 32'hA5);
        n = 0;
        while (tx_out !== 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("tx_start_seen", {31'h0, (n < 40)}, 32'h1);
        low = 0;
        while (tx_out === 1'b0 && low < 30) begin
            low++;
            @(negedge clk);
        end
        check("tx_start_len", low, 10);
        repeat (5) @(negedge clk);
        frame[0] = tx_out;
        for (int k = 1; k < 10; k++) begin
            repeat (10) @(negedge clk);
            frame[k] = tx_out;
        end
        check("tx_frame_a5", {22'h0, frame}, 32'h3A5);
        axi_read(4'h8, rd);
        check("busy_in_stop", rd, 32'h10A);
        repeat (10) @(negedge clk);
        axi_read(4'h8, rd);
        check("busy_cleared", rd, 32'h00A);

        // Loopback 0x12, 0x34
        r_loop = 1'b1;
        axi_write(4'h0, 32'h12);
        axi_write(4'h0, 32'h34);
        repeat (260) @(negedge clk);
        axi_read(4'h4, rd);
        check("lb_byte0", rd, 32'h12);
        axi_read(4'h4, rd);
        check("lb_byte1", rd, 32'h34);
        axi_read(4'h4, rd);
        check("lb_empty_read", rd, 32'h0);
        axi_read(4'h8, rd);
        check("lb_status", rd, 32'h00A);
        r_loop = 1'b0;

        // TX overflow: 1 in flight + 4 queued, sixth dropped
        mon_q.delete();
        for (int i = 1; i <= 6; i++) axi_write(4'h0, i);
        axi_read(4'h8, rd);
        check("ovf_status", rd, 32'h119);
        axi_write(4'h8, 32'h10);
        axi_read(4'h8, rd);
        check("ovf_cleared", rd, 32'h109);
        n = 0;
        while (mon_q.size() < 5 && n < 900) begin
            n++;
            @(negedge clk);
        end
        repeat (150) @(negedge clk);
        check("ovf_frames", mon_q.size(), 5);
        for (int i = 0; i < 5 && i < mon_q.size(); i++) check("ovf_byte", mon_q[i], i + 1);

        // TX flush leaves the in-flight frame alone
        mon_q.delete();
        axi_write(4'h0, 32'h11);
        axi_write(4'h0, 32'h22);
        axi_write(4'h0, 32'h33);
        axi_write(4'hC, 32'h4);
        axi_read(4'h8, rd);
        check("flush_status", rd, 32'h10A);
        axi_read(4'hC, rd);
        check("flush_reads_0", rd, 32'h0);
        repeat (250) @(negedge clk);
        check("flush_frames", mon_q.size(), 1);
        if (mon_q.size() > 0) check("flush_byte", mon_q[0], 32'h11);

        // Bad parity then bad stop: both discarded
        send_rx(8'h55, 1'b0, 1'b1);
        send_rx(8'h33, 1'b1, 1'b0);
        axi_read(4'h8, rd);
        check("err_status", rd, 32'h0CA);
        axi_write(4'h8, 32'hF0);
        axi_read(4'h8, rd);
        check("err_cleared", rd, 32'h00A);

        // RX interrupt
        axi_write(4'hC, 32'h1);
        @(negedge clk);
        check("irq_idle", {31'h0, irq}, 32'h0);
        send_rx(8'hC3, 1'b1, 1'b1);
        check("irq_rx", {31'h0, irq}, 32'h1);
        axi_read(4'h4, rd);
        check("rx_c3", rd, 32'hC3);
        @(negedge clk);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // bready held low: bvalid holds and the next write is blocked
        @(negedge clk);
        s_axi_bready  = 1'b0;
        s_axi_awaddr  = 4'hC;
        s_axi_wdata   = 32'h0;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        #1 check("hold_first_acc", {31'h0, s_axi_awready}, 32'h1);
        hold_ok    = 1'b1;
        blocked_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_axi_bvalid !== 1'b1) hold_ok = 1'b0;
            if (s_axi_awready !== 1'b0) blocked_ok = 1'b0;
        end
        check("bvalid_held", {31'h0, hold_ok}, 32'h1);
        check("awready_blocked", {31'h0, blocked_ok}, 32'h1);
        s_axi_bready = 1'b1;
        @(negedge clk);
        check("second_acc", {31'h0, s_axi_awready}, 32'h1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        @(negedge clk);

        // Reset mid-frame
        axi_write(4'hC, 32'h3);
        @(negedge clk);
        check("irq_tx_empty", {31'h0, irq}, 32'h1);
        axi_write(4'h0, 32'h00);
        repeat (30) @(negedge clk);
        check("mid_frame_low", {31'h0, tx_out}, 32'h0);
        s_axi_aresetn = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 4'h8;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        #1;
        check("rst_async_tx_out", {31'h0, tx_out}, 32'h1);
        check("rst_async_irq", {31'h0, irq}, 32'h0);
        check("rst_ready", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
        check("rst_valid", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        repeat (3) @(negedge clk);
        s_axi_aresetn = 1'b1;
        #1 check("ar_first_edge", {31'h0, s_axi_arready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check("post_rst_rvalid", {31'h0, s_axi_rvalid}, 32'h1);
        check("post_rst_status", s_axi_rdata, 32'h00A);
        axi_read(4'hC, rd);
        check("post_rst_control", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
